jk_ff_bank: RTL and testbench

//  Parametrised bank of WIDTH flip-flop channels. One run-time mode register selects how every channel reads its two control inputs:
//  JK, SR, D or T. The mode can be changed on the fly.

---
 rtl/jk_ff_pkg.sv | 14 +
 rtl/jk_ff_bank_ff_cell.sv | 76 +++++++
 rtl/jk_ff_bank.sv | 69 ++++++
 tb/tb_jk_ff_bank.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_ff_pkg.sv
// Shared types for the jk_ff_bank flip-flop array.
// Optional build macro: JKFF_TOGGLE_CNT_EN (per-channel transition counters).
package jk_ff_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_SR = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } ff_mode_t;

  localparam ff_mode_t MODE_RESET = MODE_JK;

endpackage

// File: rtl/jk_ff_bank_ff_cell.sv
// One flip-flop channel: four-mode next-state mux, q flop, illegal-SR strobe.
// Transition counter is built only when JKFF_TOGGLE_CNT_EN is defined.
module ff_cell
  import jk_ff_pkg::*;
#(
  parameter int   CNT_W     = 8,
  parameter logic RESET_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  ff_mode_t         mode,
  input  logic             a,
  input  logic             b,
  input  logic             cnt_clr,
  output logic             q,
  output logic             ill,
  output logic [CNT_W-1:0] cnt
);

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    ill   = 1'b0;
    if (en) begin
      unique case (mode)
        MODE_JK: begin
          unique case ({a, b})
            2'b01:   q_nxt = 1'b0;
            2'b10:   q_nxt = 1'b1;
            2'b11:   q_nxt = ~q;
            default: q_nxt = q;
          endcase
        end
        MODE_SR: begin
          unique case ({a, b})
            2'b01:   q_nxt = 1'b0;
            2'b10:   q_nxt = 1'b1;
            2'b11:   ill   = 1'b1;
            default: q_nxt = q;
          endcase
        end
        MODE_D:  q_nxt = a;
        MODE_T:  q_nxt = q ^ a;
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_BIT;
    end else begin
      q <= q_nxt;
    end
  end

`ifdef JKFF_TOGGLE_CNT_EN
  // Clear beats increment; saturate instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if ((q_nxt != q) && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt = '0;
`endif

endmodule

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with sticky illegal-SR flag.
// Optional build macro: JKFF_TOGGLE_CNT_EN (per-channel transition counters).
module jk_ff_bank
  import jk_ff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RESET_Q = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   mode_wr,
  input  logic [1:0]             mode_in,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   err_clr,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qb,
  output logic [1:0]             mode,
  output logic                   sr_err,
  output logic [WIDTH*CNT_W-1:0] toggle_cnt
);

  ff_mode_t         mode_q;
  logic [WIDTH-1:0] ill;

  // Cells see the registered mode, so a write lands one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_RESET;
    end else if (mode_wr) begin
      mode_q <= ff_mode_t'(mode_in);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_err <= 1'b0;
    end else if (|ill) begin
      sr_err <= 1'b1;
    end else if (err_clr) begin
      sr_err <= 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .CNT_W     (CNT_W),
      .RESET_BIT (RESET_Q[i])
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .mode    (mode_q),
      .a       (a[i]),
      .b       (b[i]),
      .cnt_clr (cnt_clr),
      .q       (q[i]),
      .ill     (ill[i]),
      .cnt     (toggle_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign qb   = ~q;
  assign mode = mode_q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Randomised self-checking bench for jk_ff_bank against a behavioural model.
module tb_jk_ff_bank;

  localparam int         W   = 8;
  localparam int         CW  = 8;
  localparam logic [7:0] RQ  = 8'hA5;
  localparam int         MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          mode_wr;
  logic [1:0]    mode_in;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          err_clr;
  logic          cnt_clr;
  logic [W-1:0]  q;
  logic [W-1:0]  qb;
  logic [1:0]    mode;
  logic          sr_err;
  logic [W*CW-1:0] toggle_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int m_q[W];
  int m_cnt[W];
  int m_mode;
  int m_err;

  jk_ff_bank #(
    .WIDTH   (W),
    .CNT_W   (CW),
    .RESET_Q (RQ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode_wr    (mode_wr),
    .mode_in    (mode_in),
    .a          (a),
    .b          (b),
    .err_clr    (err_clr),
    .cnt_clr    (cnt_clr),
    .q          (q),
    .qb         (qb),
    .mode       (mode),
    .sr_err     (sr_err),
    .toggle_cnt (toggle_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_q();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = (m_q[i] != 0);
    return v;
  endfunction

  function automatic logic [W*CW-1:0] exp_cnt();
    logic [W*CW-1:0] v;
    v = '0;
`ifdef JKFF_TOGGLE_CNT_EN
    for (int i = 0; i < W; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
`endif
    return v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < W; i++) begin
      m_q[i]   = RQ[i];
      m_cnt[i] = 0;
    end
    m_mode = 0;
    m_err  = 0;
  endfunction

  // One rising edge of the model, using the inputs currently driven.
  function automatic void m_edge();
    int any_ill;
    int ai, bi, nq;
    if (!reset) return;
    any_ill = 0;
    for (int i = 0; i < W; i++) begin
      ai = a[i];
      bi = b[i];
      nq = m_q[i];
      if (en) begin
        case (m_mode)
          0: nq = (ai && bi) ? 1 - m_q[i] : ai ? 1 : bi ? 0 : m_q[i];
          1: begin
            if (ai && bi) any_ill = 1;
            else nq = ai ? 1 : bi ? 0 : m_q[i];
          end
          2: nq = ai;
          default: nq = (m_q[i] + ai) % 2;
        endcase
      end
      if (cnt_clr) m_cnt[i] = 0;
      else if (nq != m_q[i] && m_cnt[i] < MAXC) m_cnt[i]++;
      m_q[i] = nq;
    end
    if (any_ill) m_err = 1;
    else if (err_clr) m_err = 0;
    if (mode_wr) m_mode = mode_in;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 0; mode_wr = 0; mode_in = 0;
    a = 0; b = 0; err_clr = 0; cnt_clr = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    m_reset();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      en = 1; mode_wr = 1; mode_in = 2'($urandom);
      a = 8'($urandom); b = 8'($urandom);
      tick();
      n_tests++;
      if (q !== RQ || qb !== ~RQ || mode !== 2'b00 ||
          sr_err !== 1'b0 || toggle_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: q=%h qb=%h mode=%0d err=%b cnt=%h, want q=%h qb=%h mode=0 err=0 cnt=0",
                 k, q, qb, mode, sr_err, toggle_cnt, RQ, ~RQ);
      end
    end
    idle_inputs();
    reset = 1;
  endtask

  task automatic test_jk();
    logic [7:0] va[3] = '{8'hF0, 8'hFF, 8'h00};
    logic [7:0] vb[3] = '{8'h0F, 8'hFF, 8'h00};
    logic [7:0] vq[3] = '{8'hF0, 8'h0F, 8'h0F};
    en = 1;
    for (int k = 0; k < 3; k++) begin
      a = va[k]; b = vb[k];
      tick();
      n_tests++;
      if (q !== vq[k] || q !== exp_q() || qb !== ~vq[k]) begin
        n_fail++;
        $display("FAIL jk_dir[%0d]: q=%h qb=%h want q=%h", k, q, qb, vq[k]);
      end
    end
    for (int k = 0; k < 20; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      tick();
      n_tests++;
      if (q !== exp_q() || qb !== ~exp_q() || toggle_cnt !== exp_cnt()) begin
        n_fail++;
        $display("FAIL jk_rand[%0d]: q=%h cnt=%h want q=%h cnt=%h",
                 k, q, toggle_cnt, exp_q(), exp_cnt());
      end
    end
    // return to the directed starting point q=0F
    a = 8'h00; b = 8'hF0;
    tick();
    a = 8'h0F; b = 8'h00;
    tick();
  endtask

  task automatic test_mode_switch();
    mode_wr = 1; mode_in = 2'b10; en = 1; a = 8'h33; b = 8'h00;
    tick();
    n_tests++;
    if (q !== 8'h3F || mode !== 2'b10 || q !== exp_q()) begin
      n_fail++;
      $display("FAIL mode_sw_old: q=%h mode=%0d want q=3f mode=2", q, mode);
    end
    mode_wr = 0; a = 8'h33;
    tick();
    n_tests++;
    if (q !== 8'h33 || q !== exp_q()) begin
      n_fail++;
      $display("FAIL mode_sw_new: q=%h want 33", q);
    end
  endtask

  task automatic test_sr();
    mode_wr = 1; mode_in = 2'b01; en = 1; a = 8'h00; b = 8'h00;
    tick();
    mode_wr = 0; a = 8'h01; b = 8'h01;
    tick();
    n_tests++;
    if (q !== 8'h00 || sr_err !== 1'b1 || mode !== 2'b01) begin
      n_fail++;
      $display("FAIL sr_illegal: q=%h err=%b mode=%0d want q=00 err=1 mode=1", q, sr_err, mode);
    end
    err_clr = 1; a = 8'h02; b = 8'h02;
    tick();
    n_tests++;
    if (sr_err !== 1'b1 || q !== 8'h00) begin
      n_fail++;
      $display("FAIL sr_set_wins: err=%b q=%h want err=1 q=00", sr_err, q);
    end
    a = 8'h00; b = 8'h00;
    tick();
    n_tests++;
    if (sr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sr_clear: err=%b want 0", sr_err);
    end
    err_clr = 0;
    for (int k = 0; k < 20; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      err_clr = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 4) != 0);
      tick();
      n_tests++;
      if (q !== exp_q() || sr_err !== m_err[0]) begin
        n_fail++;
        $display("FAIL sr_rand[%0d]: q=%h err=%b want q=%h err=%0d",
                 k, q, sr_err, exp_q(), m_err);
      end
    end
    en = 1; err_clr = 0;
  endtask

  task automatic test_toggle();
    logic       prev;
    logic [7:0] c0;
    logic [W-1:0]    hq;
    logic [W*CW-1:0] hc;
    mode_wr = 1; mode_in = 2'b11; en = 0; a = 0; b = 0;
    tick();
    mode_wr = 0; en = 1; a = 8'h01; b = 8'($urandom);
    prev = q[0];
    for (int k = 0; k < 260; k++) begin
      tick();
      if (k % 20 == 0 || k == 259) begin
        n_tests++;
        if (q[0] !== ~prev || q !== exp_q() || toggle_cnt !== exp_cnt()) begin
          n_fail++;
          $display("FAIL toggle[%0d]: q=%h cnt0=%h want q=%h cnt0=%h",
                   k, q, toggle_cnt[7:0], exp_q(), exp_cnt() >> 0);
        end
      end
      prev = q[0];
    end
    c0 = toggle_cnt[7:0];
    n_tests++;
`ifdef JKFF_TOGGLE_CNT_EN
    if (c0 !== 8'hFF) begin
`else
    if (c0 !== 8'h00) begin
`endif
      n_fail++;
      $display("FAIL cnt_saturate: cnt0=%h", c0);
    end
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    n_tests++;
    if (toggle_cnt !== '0 || q !== exp_q()) begin
      n_fail++;
      $display("FAIL cnt_clr: cnt=%h q=%h want cnt=0 q=%h", toggle_cnt, q, exp_q());
    end
    tick();
    en = 0;
    hq = q; hc = toggle_cnt;
    for (int k = 0; k < 5; k++) begin
      a = 8'($urandom); b = 8'($urandom);
      tick();
      n_tests++;
      if (q !== hq || toggle_cnt !== hc || q !== exp_q() || toggle_cnt !== exp_cnt()) begin
        n_fail++;
        $display("FAIL en_hold[%0d]: q=%h cnt=%h want q=%h cnt=%h", k, q, toggle_cnt, hq, hc);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      en      = ($urandom_range(0, 3) != 0);
      mode_wr = ($urandom_range(0, 6) == 0);
      mode_in = 2'($urandom);
      a       = 8'($urandom);
      b       = 8'($urandom);
      err_clr = ($urandom_range(0, 9) == 0);
      cnt_clr = ($urandom_range(0, 19) == 0);
      tick();
      n_tests++;
      if (q !== exp_q() || qb !== ~exp_q() || mode !== 2'(m_mode) ||
          sr_err !== m_err[0] || toggle_cnt !== exp_cnt()) begin
        n_fail++;
        $display("FAIL random[%0d]: q=%h mode=%0d err=%b cnt=%h want q=%h mode=%0d err=%0d cnt=%h",
                 k, q, mode, sr_err, toggle_cnt, exp_q(), m_mode, m_err, exp_cnt());
      end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    mode_wr = 1; mode_in = 2'b11; en = 1;
    tick();
    mode_wr = 0; a = 8'h5A; b = 8'h00;
    for (int k = 0; k < 5; k++) tick();
    #2;
    reset = 0;
    mode_wr = 1; mode_in = 2'b10;
    m_reset();
    #1;
    n_tests++;
    if (q !== RQ || qb !== ~RQ || mode !== 2'b00 || sr_err !== 1'b0 || toggle_cnt !== '0) begin
      n_fail++;
      $display("FAIL async_reset: q=%h mode=%0d err=%b want q=%h mode=0 err=0", q, mode, sr_err, RQ);
    end
    tick();
    n_tests++;
    if (mode !== 2'b00 || q !== RQ) begin
      n_fail++;
      $display("FAIL reset_abort_wr: mode=%0d q=%h want mode=0 q=%h", mode, q, RQ);
    end
    reset = 1; mode_wr = 0; en = 1; a = 8'h03; b = 8'h00;
    tick();
    n_tests++;
    if (q !== 8'hA7 || q !== exp_q() || mode !== 2'b00) begin
      n_fail++;
      $display("FAIL post_release: q=%h mode=%0d want q=a7 mode=0", q, mode);
    end
  endtask

  initial begin
    test_reset();
    test_jk();
    test_mode_switch();
    test_sr();
    test_toggle();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
